octave_tone_gen: RTL and testbench

Parametrised successor to the fixed 12-output octave divider. It keeps a saturating octave state driven by edge-detected up/down buttons. It derives one divider per voice from a shared middle-octave base table. Unlike the previous block, it also generates a gated square-wave tone per voice, ready for the mixer stage.

---
 rtl/octave_tone_pkg.sv | 31 +++
 rtl/octave_tone_gen_tone_channel.sv | 38 +++
 rtl/octave_tone_gen.sv | 110 +++++++++++
 tb/tb_octave_tone_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/octave_tone_pkg.sv
// Shared constants and helpers for octave_tone_gen.
//   BASE_DIV   : middle-octave full-period dividers for a 10 MHz clock
//   OCT_W      : width of the octave index
//   oct_evt_e  : decoded button event for the octave state machine
//   shift_div  : octave-shift a divider, saturating to all-ones on overflow
package octave_tone_pkg;

  localparam int OCT_W = 3;

  localparam int BASE_DIV [0:11] = '{38222, 36077, 34052, 32141, 30337, 28635,
                                     27027, 25511, 24079, 22727, 21452, 20248};

  typedef enum logic [1:0] {EV_NONE, EV_UP, EV_DOWN} oct_evt_e;

  // s >= 0 lowers the pitch request into a smaller divider (higher note);
  // s < 0 multiplies the divider and clamps if it no longer fits in w bits.
  function automatic logic [31:0] shift_div(input logic [31:0] base, input int s,
                                            input int w);
    logic [31:0] lim;
    logic [31:0] v;
    lim = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    if (s >= 0) begin
      v = base >> s;
    end else begin
      v = base << (-s);
      if (((v >> (-s)) != base) || (v > lim)) v = lim;
    end
    return v;
  endfunction

endpackage

// File: rtl/octave_tone_gen_tone_channel.sv
// One voice: half-period counter, toggle flop and gate.
//   clk, nrst : clock, synchronous active-low reset
//   en_i      : 1 = run; 0 clears counter and forces tone low
//   div_i     : full-period divider; tone period is 2*(div_i>>1) cycles
//   tone_o    : square-wave output (held low when div_i < 2)
module tone_channel #(
  parameter int DIV_W = 18
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tone_o
);

  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] cnt_q;
  logic             tone_q;

  assign half   = div_i >> 1;
  assign tone_o = tone_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else if (!en_i || (half == '0)) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else if (cnt_q == half - DIV_W'(1)) begin
      cnt_q  <= '0;
      tone_q <= ~tone_q;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/octave_tone_gen.sv
// Octave-switchable multi-voice tone generator.
//   clk, nrst               : clock (10 MHz), synchronous active-low reset
//   octave_up, octave_down  : debounced button levels, edge-detected here
//   key_en[NUM_VOICES]      : per-voice gate
//   octave                  : current octave index (0 = lowest)
//   changed                 : one-cycle pulse when octave actually changes
//   div                     : per-voice divider, voice i at [i*DIV_W +: DIV_W]
//   tone[NUM_VOICES]        : per-voice square wave
// Build option: define OCTAVE_WRAP_EN to make the octave wrap at both ends
// instead of saturating.
module octave_tone_gen
  import octave_tone_pkg::*;
#(
  parameter int NUM_VOICES = 12,
  parameter int DIV_W      = 18,
  parameter int OCT_LEVELS = 5,
  parameter int OCT_MID    = 2
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        octave_up,
  input  logic                        octave_down,
  input  logic [NUM_VOICES-1:0]       key_en,
  output logic [2:0]                  octave,
  output logic                        changed,
  output logic [NUM_VOICES*DIV_W-1:0] div,
  output logic [NUM_VOICES-1:0]       tone
);

  localparam logic [OCT_W-1:0] OCT_TOP = OCT_W'(OCT_LEVELS - 1);
  localparam logic [OCT_W-1:0] OCT_RST = OCT_W'(OCT_MID);

  logic                                up_q, down_q;
  logic                                up_evt, down_evt;
  oct_evt_e                            evt;
  logic [OCT_W-1:0]                    oct_q, oct_d, div_oct;
  logic                                chg_q, chg_d;
  logic [NUM_VOICES-1:0][DIV_W-1:0]    div_q, div_d;

  assign up_evt   = octave_up & ~up_q;
  assign down_evt = octave_down & ~down_q;

  // Octave next-state: simultaneous events cancel.
  always_comb begin
    evt   = EV_NONE;
    oct_d = oct_q;
    if (up_evt && !down_evt)      evt = EV_UP;
    else if (down_evt && !up_evt) evt = EV_DOWN;
    case (evt)
      EV_UP: begin
        if (oct_q != OCT_TOP) oct_d = oct_q + OCT_W'(1);
`ifdef OCTAVE_WRAP_EN
        else                  oct_d = '0;
`endif
      end
      EV_DOWN: begin
        if (oct_q != '0) oct_d = oct_q - OCT_W'(1);
`ifdef OCTAVE_WRAP_EN
        else             oct_d = OCT_TOP;
`endif
      end
      default: ;
    endcase
    chg_d = (oct_d != oct_q);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
      oct_q  <= OCT_RST;
      chg_q  <= 1'b0;
    end else begin
      up_q   <= octave_up;
      down_q <= octave_down;
      oct_q  <= oct_d;
      chg_q  <= chg_d;
    end
  end

  // Dividers track the octave being loaded this edge, so on the changed
  // cycle div already holds the new period.
  assign div_oct = nrst ? oct_d : OCT_RST;

  always_ff @(posedge clk) div_q <= div_d;

  genvar v;
  generate
    for (v = 0; v < NUM_VOICES; v++) begin : g_voice
      localparam int NOTE    = v % 12;
      localparam int OCT_OFF = v / 12;

      assign div_d[v] = DIV_W'(shift_div(32'(BASE_DIV[NOTE]),
                                         int'(div_oct) - OCT_MID + OCT_OFF, DIV_W));
      assign div[v*DIV_W +: DIV_W] = div_q[v];

      tone_channel #(.DIV_W(DIV_W)) u_ch (
        .clk   (clk),
        .nrst  (nrst),
        .en_i  (key_en[v] & ~chg_q),
        .div_i (div_q[v]),
        .tone_o(tone[v])
      );
    end
  endgenerate

  assign octave  = oct_q;
  assign changed = chg_q;

endmodule

// File: tb/tb_octave_tone_gen.sv
module tb_octave_tone_gen;

  localparam int NV  = 24;
  localparam int DW  = 18;
  localparam int OL  = 5;
  localparam int OM  = 2;
  localparam int SAT = (1 << DW) - 1;

  int BASE [12] = '{38222, 36077, 34052, 32141, 30337, 28635,
                    27027, 25511, 24079, 22727, 21452, 20248};

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             up = 1'b0, dn = 1'b0;
  logic [NV-1:0]    key_en = '0;
  logic [2:0]       octave;
  logic             changed;
  logic [NV*DW-1:0] div;
  logic [NV-1:0]    tone;

  octave_tone_gen #(.NUM_VOICES(NV), .DIV_W(DW), .OCT_LEVELS(OL), .OCT_MID(OM)) dut (
    .clk(clk), .nrst(nrst), .octave_up(up), .octave_down(dn), .key_en(key_en),
    .octave(octave), .changed(changed), .div(div), .tone(tone)
  );

  always #5 clk = ~clk;

  // Expected divider straight from the arithmetic rule.
  function automatic int exp_div(int o, int i);
    int     s;
    longint v;
    s = (o - OM) + i / 12;
    if (s >= 0) return BASE[i % 12] / (1 << s);
    v = longint'(BASE[i % 12]) * (longint'(1) << (-s));
    return (v > SAT) ? SAT : int'(v);
  endfunction

  // Model: octave as an integer, and per voice the number of enabled edges
  // since the last clear plus the half-period in force while counting.
  int  m_oct = OM;
  bit  m_chg = 0, m_up_p = 0, m_dn_p = 0, m_valid = 0;
  int  m_k [NV];
  int  m_h [NV];

  always @(posedge clk) begin
    int n;
    if (!nrst) begin
      m_oct = OM; m_chg = 0; m_up_p = 0; m_dn_p = 0; m_valid = 1;
      for (int i = 0; i < NV; i++) begin m_k[i] = 0; m_h[i] = 1; end
    end else begin
      for (int i = 0; i < NV; i++) begin
        int h;
        h = exp_div(m_oct, i) / 2;
        if (!key_en[i] || m_chg || h < 1) m_k[i] = 0;
        else begin m_k[i]++; m_h[i] = h; end
      end
      n = m_oct;
      if (up && !m_up_p && !(dn && !m_dn_p)) begin
        if (m_oct < OL - 1) n = m_oct + 1;
`ifdef OCTAVE_WRAP_EN
        else n = 0;
`endif
      end else if (dn && !m_dn_p && !(up && !m_up_p)) begin
        if (m_oct > 0) n = m_oct - 1;
`ifdef OCTAVE_WRAP_EN
        else n = OL - 1;
`endif
      end
      m_chg = (n != m_oct);
      m_oct = n;
      m_up_p = up; m_dn_p = dn;
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    if (!m_valid) return;
    chk("octave", octave, m_oct);
    chk("changed", changed, m_chg);
    for (int i = 0; i < NV; i++) begin
      int et;
      chk($sformatf("div[%0d]", i), div[i*DW +: DW], exp_div(m_oct, i));
      et = (m_k[i] == 0) ? 0 : (m_k[i] / m_h[i]) % 2;
      chk($sformatf("tone[%0d]", i), tone[i], et);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0; up = 1'b0; dn = 1'b0;
    step(2);
    nrst = 1'b1;
  endtask

  task automatic pulse_up();
    up = 1'b1; step(); up = 1'b0; step();
  endtask

  task automatic pulse_dn();
    dn = 1'b1; step(); dn = 1'b0; step();
  endtask

  initial begin
    // 1: reset defaults
    do_reset();
    chk("rst octave", octave, 2);
    chk("rst changed", changed, 0);
    chk("rst div0", div[0 +: DW], 38222);
    chk("rst div9", div[9*DW +: DW], 22727);
    chk("rst div12", div[12*DW +: DW], 19111);
    chk("rst div23", div[23*DW +: DW], 10124);
    chk("rst tone", tone, 0);
    step();

    // 2: up pulses and top boundary
    up = 1'b1; step();
    chk("up1 octave", octave, 3);
    chk("up1 changed", changed, 1);
    chk("up1 div0", div[0 +: DW], 19111);
    up = 1'b0; step();
    chk("up1 changed clears", changed, 0);
    up = 1'b1; step();
    chk("up2 octave", octave, 4);
    chk("up2 div0", div[0 +: DW], 9555);
    up = 1'b0; step();
    up = 1'b1; step();
`ifdef OCTAVE_WRAP_EN
    chk("up3 wrap octave", octave, 0);
    chk("up3 wrap changed", changed, 1);
    chk("up3 wrap div0", div[0 +: DW], 152888);
`else
    chk("up3 hold octave", octave, 4);
    chk("up3 hold changed", changed, 0);
`endif
    up = 1'b0; step();

    // 3: held button, simultaneous buttons
    do_reset(); step();
    up = 1'b1; step(10); up = 1'b0; step();
    chk("held up octave", octave, 3);
    up = 1'b1; dn = 1'b1; step();
    chk("both octave", octave, 3);
    chk("both changed", changed, 0);
    up = 1'b0; dn = 1'b0; step();

    // 4: downs and bottom boundary
    do_reset(); step();
    pulse_dn(); pulse_dn();
    chk("dn2 octave", octave, 0);
    chk("dn2 div0", div[0 +: DW], 152888);
    chk("dn2 div9", div[9*DW +: DW], 90908);
    chk("dn2 div12", div[12*DW +: DW], 76444);
    pulse_dn();
`ifdef OCTAVE_WRAP_EN
    chk("dn3 wrap octave", octave, 4);
    chk("dn3 wrap div0", div[0 +: DW], 9555);
`else
    chk("dn3 hold octave", octave, 0);
`endif

    // 5: tones at octave 4, then a change mid-tone
    do_reset(); step();
    pulse_up(); pulse_up();
    chk("oct4 div23", div[23*DW +: DW], 2531);
    key_en[0] = 1'b1; key_en[5] = 1'b1; key_en[23] = 1'b1;
    step(4776);
    chk("tone0 before half", tone[0], 0);
    step();
    chk("tone0 at half", tone[0], 1);
    step(300);
    key_en[5] = 1'b0;
    step(50);
    dn = 1'b1; step();
    chk("mid dn octave", octave, 3);
    chk("mid dn changed", changed, 1);
    dn = 1'b0; step();
    chk("tone0 cleared", tone[0], 0);
    step(9554);
    chk("tone0 new before half", tone[0], 0);
    step();
    chk("tone0 new at half", tone[0], 1);
    key_en[5] = 1'b1;
    step(3000);

    // 6: reset mid-operation
    nrst = 1'b0; step();
    chk("midrst octave", octave, 2);
    chk("midrst tone", tone, 0);
    chk("midrst changed", changed, 0);
    nrst = 1'b1; key_en = '0;
    step(5);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
